// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI master arbiter: FSM states, AXI burst/response
// encodings and the AxSIZE helper.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } arb_state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // AxSIZE encoding for a full-width beat of the given data bus.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
// Purely combinational; one-hot grant plus its index.
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= NUM_W) sum = sum - NUM_W;
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ simple command ports onto one AXI4
// master, one transaction outstanding at a time.
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 64,
  parameter int AXI4_ID_WIDTH      = 4
) (
  input  logic                                       ACLK,
  input  logic                                       ARESETn,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [NUM_REQ-1:0]                         req_write,
  input  logic [NUM_REQ*AXI4_ADDRESS_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*8-1:0]                       req_len,
  input  logic [NUM_REQ*AXI4_DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_REQ*(AXI4_DATA_WIDTH/8)-1:0]     req_wstrb,
  input  logic [NUM_REQ-1:0]                         req_wvalid,
  output logic [NUM_REQ-1:0]                         req_wready,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  output logic [AXI4_DATA_WIDTH-1:0]                 rsp_data,
  output logic [1:0]                                 rsp_resp,
  output logic                                       rsp_last,
  output logic                                       AWVALID,
  input  logic                                       AWREADY,
  output logic [AXI4_ADDRESS_WIDTH-1:0]              AWADDR,
  output logic [7:0]                                 AWLEN,
  output logic [2:0]                                 AWSIZE,
  output logic [1:0]                                 AWBURST,
  output logic [AXI4_ID_WIDTH-1:0]                   AWID,
  output logic                                       WVALID,
  input  logic                                       WREADY,
  output logic [AXI4_DATA_WIDTH-1:0]                 WDATA,
  output logic [AXI4_DATA_WIDTH/8-1:0]               WSTRB,
  output logic                                       WLAST,
  input  logic                                       BVALID,
  output logic                                       BREADY,
  input  logic [1:0]                                 BRESP,
  output logic                                       ARVALID,
  input  logic                                       ARREADY,
  output logic [AXI4_ADDRESS_WIDTH-1:0]              ARADDR,
  output logic [7:0]                                 ARLEN,
  output logic [2:0]                                 ARSIZE,
  output logic [1:0]                                 ARBURST,
  output logic [AXI4_ID_WIDTH-1:0]                   ARID,
  input  logic                                       RVALID,
  output logic                                       RREADY,
  input  logic [AXI4_DATA_WIDTH-1:0]                 RDATA,
  input  logic [1:0]                                 RRESP,
  input  logic                                       RLAST
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;

  logic [AXI4_ADDRESS_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [7:0]                    len_arr   [NUM_REQ];
  logic [AXI4_DATA_WIDTH-1:0]    wdata_arr [NUM_REQ];
  logic [STRB_W-1:0]             wstrb_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AXI4_ADDRESS_WIDTH +: AXI4_ADDRESS_WIDTH];
      assign len_arr[gi]   = req_len[gi*8 +: 8];
      assign wdata_arr[gi] = req_wdata[gi*AXI4_DATA_WIDTH +: AXI4_DATA_WIDTH];
      assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

  arb_state_t                    state_reg;
  logic [IDX_W-1:0]              owner_reg;
  logic [IDX_W-1:0]              rr_ptr_reg;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_reg;
  logic [7:0]                    len_reg;
  logic [7:0]                    beat_cnt_reg;
  logic [NUM_REQ-1:0]            req_ready_reg;
  logic                          aw_valid_reg;
  logic                          ar_valid_reg;
  logic                          bready_reg;
  logic                          rready_reg;
  logic [NUM_REQ-1:0]            rsp_valid_reg;
  logic [AXI4_DATA_WIDTH-1:0]    rsp_data_reg;
  logic [1:0]                    rsp_resp_reg;
  logic                          rsp_last_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [IDX_W-1:0]   next_ptr;
  logic               in_wdata;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign owner_onehot = NUM_REQ'(1) << owner_reg;
  assign next_ptr     = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);
  assign in_wdata     = (state_reg == ST_WDATA);

  // Write beats stream straight through from the owner so WVALID/WREADY stay
  // a same-cycle handshake end to end.
  assign WVALID     = in_wdata & req_wvalid[owner_reg];
  assign WDATA      = wdata_arr[owner_reg];
  assign WSTRB      = wstrb_arr[owner_reg];
  assign WLAST      = in_wdata & (beat_cnt_reg == len_reg);
  assign req_wready = (in_wdata & WREADY) ? owner_onehot : '0;

  assign AWVALID = aw_valid_reg;
  assign AWADDR  = addr_reg;
  assign AWLEN   = len_reg;
  assign AWSIZE  = axi_size(AXI4_DATA_WIDTH);
  assign AWBURST = BURST_INCR;
  assign AWID    = AXI4_ID_WIDTH'(owner_reg);
  assign ARVALID = ar_valid_reg;
  assign ARADDR  = addr_reg;
  assign ARLEN   = len_reg;
  assign ARSIZE  = axi_size(AXI4_DATA_WIDTH);
  assign ARBURST = BURST_INCR;
  assign ARID    = AXI4_ID_WIDTH'(owner_reg);
  assign BREADY  = bready_reg;
  assign RREADY  = rready_reg;

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign rsp_last  = rsp_last_reg;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      req_ready_reg <= '0;
      aw_valid_reg  <= 1'b0;
      ar_valid_reg  <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_resp_reg  <= RESP_OKAY;
      rsp_last_reg  <= 1'b0;
    end else begin
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_last_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) begin
            owner_reg     <= grant_idx;
            req_ready_reg <= grant;
            addr_reg      <= addr_arr[grant_idx];
            len_reg       <= len_arr[grant_idx];
            aw_valid_reg  <= req_write[grant_idx];
            ar_valid_reg  <= ~req_write[grant_idx];
            state_reg     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_valid_reg && AWREADY) begin
            aw_valid_reg <= 1'b0;
            beat_cnt_reg <= '0;
            state_reg    <= ST_WDATA;
          end else if (ar_valid_reg && ARREADY) begin
            ar_valid_reg <= 1'b0;
            rready_reg   <= 1'b1;
            state_reg    <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (WVALID && WREADY) begin
            if (WLAST) begin
              bready_reg <= 1'b1;
              state_reg  <= ST_WRESP;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            bready_reg    <= 1'b0;
            beat_cnt_reg  <= '0;
            rsp_valid_reg <= owner_onehot;
            rsp_resp_reg  <= BRESP;
            rsp_last_reg  <= 1'b1;
            rr_ptr_reg    <= next_ptr;
            state_reg     <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (RVALID) begin
            rsp_valid_reg <= owner_onehot;
            rsp_data_reg  <= RDATA;
            rsp_resp_reg  <= RRESP;
            rsp_last_reg  <= RLAST;
            if (RLAST) begin
              rready_reg <= 1'b0;
              rr_ptr_reg <= next_ptr;
              state_reg  <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a hand-driven AXI slave and
// requesters, expected values written out per step.
module tb_axi_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*8-1:0]  req_len = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*DW/8-1:0] req_wstrb = '0;
  logic [N-1:0]    req_wvalid = '0;
  logic [N-1:0]    req_wready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_resp;
  logic            rsp_last;
  logic            AWVALID, AWREADY = 1'b1;
  logic [AW-1:0]   AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic [IW-1:0]   AWID;
  logic            WVALID, WREADY = 1'b0;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST;
  logic            BVALID = 1'b0, BREADY;
  logic [1:0]      BRESP = 2'd0;
  logic            ARVALID, ARREADY = 1'b1;
  logic [AW-1:0]   ARADDR;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic [IW-1:0]   ARID;
  logic            RVALID = 1'b0, RREADY;
  logic [DW-1:0]   RDATA = '0;
  logic [1:0]      RRESP = 2'd0;
  logic            RLAST = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter #(
    .NUM_REQ(N), .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cmd(input int g, input bit wr, input logic [31:0] addr, input logic [7:0] len);
    req_write[g] = wr;
    req_addr[g*AW +: AW] = addr;
    req_len[g*8 +: 8] = len;
    req_valid[g] = 1'b1;
  endtask

  // Called with the controller idle and requester g the one that will win.
  task automatic rd_txn(input int g, input logic [31:0] addr, input logic [7:0] len,
                        input logic [63:0] base, input bit drop);
    tick();
    chk("rd_grant", req_ready, 64'(1) << g);
    chk("rd_arvalid", ARVALID, 1);
    chk("rd_awvalid_excl", AWVALID, 0);
    chk("rd_arid", ARID, g);
    chk("rd_araddr", ARADDR, addr);
    chk("rd_arlen", ARLEN, len);
    chk("rd_arburst", ARBURST, 1);
    if (drop) req_valid[g] = 1'b0;
    tick();
    chk("rd_ar_done", ARVALID, 0);
    chk("rd_rready", RREADY, 1);
    chk("rd_ready_pulse", req_ready, 0);
    for (int b = 0; b <= int'(len); b++) begin
      RVALID = 1'b1;
      RDATA = base + 64'(b);
      RRESP = 2'd0;
      RLAST = (b == int'(len));
      tick();
      chk("rd_rsp_valid", rsp_valid, 64'(1) << g);
      chk("rd_rsp_data", rsp_data, base + 64'(b));
      chk("rd_rsp_last", rsp_last, (b == int'(len)) ? 1 : 0);
    end
    RVALID = 1'b0;
    RLAST = 1'b0;
    $display("txn req%0d read addr=0x%0h len=%0d", g, addr, len);
  endtask

  task automatic wr_txn(input int g, input logic [31:0] addr, input logic [7:0] len,
                        input logic [63:0] base, input int delay, input logic [1:0] resp);
    tick();
    chk("wr_grant", req_ready, 64'(1) << g);
    chk("wr_awvalid", AWVALID, 1);
    chk("wr_arvalid_excl", ARVALID, 0);
    chk("wr_awid", AWID, g);
    chk("wr_awaddr", AWADDR, addr);
    chk("wr_awlen", AWLEN, len);
    chk("wr_awsize", AWSIZE, 3);
    req_valid[g] = 1'b0;
    tick();
    chk("wr_aw_done", AWVALID, 0);
    for (int b = 0; b <= int'(len); b++) begin
      req_wvalid[g] = 1'b1;
      req_wdata[g*DW +: DW] = base + 64'(b);
      req_wstrb[g*8 +: 8] = 8'hFF;
      WREADY = 1'b0;
      for (int d = 0; d < delay; d++) begin
        #1;
        chk("wr_wait_wvalid", WVALID, 1);
        chk("wr_wait_wready", req_wready, 0);
        chk("wr_wait_wlast", WLAST, (b == int'(len)) ? 1 : 0);
        tick();
      end
      WREADY = 1'b1;
      #1;
      chk("wr_wdata", WDATA, base + 64'(b));
      chk("wr_wlast", WLAST, (b == int'(len)) ? 1 : 0);
      chk("wr_wready_route", req_wready, 64'(1) << g);
      tick();
    end
    WREADY = 1'b0;
    req_wvalid[g] = 1'b0;
    #1;
    chk("wr_bready", BREADY, 1);
    chk("wr_no_early_rsp", rsp_valid, 0);
    BVALID = 1'b1;
    BRESP = resp;
    tick();
    chk("wr_rsp_valid", rsp_valid, 64'(1) << g);
    chk("wr_rsp_resp", rsp_resp, resp);
    chk("wr_rsp_last", rsp_last, 1);
    BVALID = 1'b0;
    BRESP = 2'd0;
    $display("txn req%0d write addr=0x%0h len=%0d bresp=%0d", g, addr, len, resp);
  endtask

  initial begin
    // Reset held with every requester asking for a single-beat read.
    for (int g = 0; g < N; g++) set_cmd(g, 1'b0, 32'h1000 * (g + 1), 8'd0);
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wlast", WLAST, 0);
    ARESETn = 1'b1;

    // All four valid from reset exit: grants go 0,1,2,3 then back to 0.
    rd_txn(0, 32'h1000, 8'd0, 64'hC0, 1'b0);
    rd_txn(1, 32'h2000, 8'd0, 64'hC1, 1'b0);
    rd_txn(2, 32'h3000, 8'd0, 64'hC2, 1'b0);
    rd_txn(3, 32'h4000, 8'd0, 64'hC3, 1'b0);
    rd_txn(0, 32'h1000, 8'd0, 64'hC4, 1'b0);
    req_valid = '0;

    // Four-beat write from requester 0; response seen exactly once.
    set_cmd(0, 1'b1, 32'h100, 8'd3);
    wr_txn(0, 32'h100, 8'd3, 64'hA0, 0, 2'd0);
    tick();
    chk("wr0_rsp_once", rsp_valid, 0);

    // Eight-beat read for requester 2.
    set_cmd(2, 1'b0, 32'h2000, 8'd7);
    rd_txn(2, 32'h2000, 8'd7, 64'h10, 1'b1);
    tick();
    chk("rd2_rsp_done", rsp_valid, 0);

    // Reset during the third write beat of a len 7 burst from requester 2.
    set_cmd(2, 1'b1, 32'h600, 8'd7);
    tick();
    chk("abort_grant", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    for (int b = 0; b < 2; b++) begin
      req_wvalid[2] = 1'b1;
      req_wdata[2*DW +: DW] = 64'hD0 + 64'(b);
      WREADY = 1'b1;
      tick();
    end
    req_wvalid[2] = 1'b1;
    req_wdata[2*DW +: DW] = 64'hD2;
    #1;
    chk("abort_wvalid_before", WVALID, 1);
    ARESETn = 1'b0;
    #1;
    chk("abort_wvalid", WVALID, 0);
    chk("abort_wready", req_wready, 0);
    chk("abort_wlast", WLAST, 0);
    chk("abort_rsp", rsp_valid, 0);
    WREADY = 1'b0;
    req_wvalid = '0;
    set_cmd(0, 1'b0, 32'h40, 8'd0);
    set_cmd(2, 1'b1, 32'h600, 8'd7);
    tick();
    chk("abort_held_ready", req_ready, 0);
    chk("abort_held_bready", BREADY, 0);
    ARESETn = 1'b1;
    rd_txn(0, 32'h40, 8'd0, 64'h77, 1'b1);
    req_valid = '0;

    // SLVERR on requester 1 write goes to requester 1 only.
    set_cmd(1, 1'b1, 32'h500, 8'd1);
    wr_txn(1, 32'h500, 8'd1, 64'hB0, 0, 2'd2);
    // Pointer now 2: requester 3 beats requester 0, then 0 follows.
    set_cmd(0, 1'b0, 32'h80, 8'd0);
    set_cmd(3, 1'b0, 32'h90, 8'd0);
    rd_txn(3, 32'h90, 8'd0, 64'hE3, 1'b1);
    rd_txn(0, 32'h80, 8'd0, 64'hE0, 1'b1);

    // Single-beat write with WREADY held off for five cycles.
    set_cmd(3, 1'b1, 32'h300, 8'd0);
    wr_txn(3, 32'h300, 8'd0, 64'h55, 5, 2'd0);

    // Longest burst: 256 beats through the 8-bit counter.
    set_cmd(1, 1'b1, 32'h8000, 8'd255);
    wr_txn(1, 32'h8000, 8'd255, 64'h1000, 0, 2'd0);
    tick();
    chk("len255_idle", AWVALID | ARVALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_master_arbiter.md
AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, address width.
REQ-003 SHALL have parameter AXI4_DATA_WIDTH, default 64, R/W data width.
REQ-004 SHALL have parameter AXI4_ID_WIDTH, default 4, ID width (>= clog2(NUM_REQ)).
REQ-005 SHALL have port ACLK  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port ARESETn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester command valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot command accept.
REQ-009 SHALL have port req_write  input  NUM_REQ  1=write, 0=read.
REQ-010 SHALL have port req_addr  input  NUM_REQ*ADDR  packed start addresses.
REQ-011 SHALL have port req_len  input  NUM_REQ*8  packed AXLEN (beats-1).
REQ-012 SHALL have port req_wdata / req_wstrb / req_wvalid  input  NUM_REQ*DATA / NUM_REQ*DATA/8 / NUM_REQ  packed write beats.
REQ-013 SHALL have port req_wready  output  NUM_REQ  write-beat accept, owner only.
REQ-014 SHALL have port rsp_valid  output  NUM_REQ  one-hot response/read-beat strobe.
REQ-015 SHALL have port rsp_data / rsp_resp / rsp_last  output  DATA / 2 / 1  shared response payload.
REQ-016 SHALL have AXI4 master ports AW*, W*, B*, AR*, R* (VALID/READY/ADDR/LEN/SIZE/BURST/ID/DATA/STRB/LAST/RESP) of the given widths.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WDATA, WRESP, RDATA; one transaction outstanding at a time.
REQ-018 IDLE: SHALL select first asserted req_valid scanning from rr_ptr upward with wrap; pulse req_ready[owner] one cycle, latch write/addr/len, go ADDR next cycle.
REQ-019 ADDR: SHALL hold AWVALID (write) or ARVALID (read) with latched fields, AxID=owner, AxBURST=INCR, AxSIZE=log2(DATA/8); on handshake go WDATA or RDATA.
REQ-020 WDATA: SHALL mux owner's wdata/wstrb/wvalid onto W, route WREADY to req_wready[owner], count beats, WLAST=1 when count==len; after last handshake go WRESP.
REQ-021 WRESP: BREADY=1; on BVALID SHALL pulse rsp_valid[owner] with rsp_resp=BRESP, rsp_last=1, go IDLE.
REQ-022 RDATA: RREADY=1; each RVALID SHALL drive rsp_valid[owner], rsp_data=RDATA, rsp_resp=RRESP, rsp_last=RLAST; RLAST handshake -> IDLE.
REQ-023 SHALL set rr_ptr=(owner+1) mod NUM_REQ on returning to IDLE; no requester starves.
REQ-024 Simultaneous requests SHALL be resolved only by rr_ptr; req_valid changes after grant SHALL not affect the active transaction.
REQ-025 req_wready and rsp_valid for non-owners SHALL be 0 at all times; AW/AR VALID SHALL never be asserted together.
REQ-026 len=0 SHALL give single beat with WLAST on first beat; len=255 SHALL give 256 beats, 8-bit counter without overflow error.
REQ-027 Error responses (SLVERR/DECERR) SHALL be passed through unchanged; FSM flow unchanged.

Reset
REQ-028 ARESETn low SHALL asynchronously force IDLE, rr_ptr=0, beat count=0, all VALID/READY/LAST outputs and req_ready/req_wready/rsp_valid to 0.
REQ-029 Reset mid-transaction SHALL abandon it; no response issued; first post-reset grant follows REQ-018 with rr_ptr=0.

Structure
REQ-030 FSM state enum, AXI BURST/SIZE/RESP constants SHALL live in shared package axi_arb_pkg.
REQ-031 Round-robin selection SHALL be sub-module rr_select (req vector, pointer in; one-hot grant, index out; combinational).

Verification
REQ-032 Req0 write addr 0x100 len 3 data 0xA0..0xA3 -> 4 W beats, WLAST on 4th, rsp_valid[0] once, rsp_resp=0.
REQ-033 Req0..3 all valid at reset exit -> grant order 0,1,2,3,0; each completes before next AW/AR.
REQ-034 Req2 read addr 0x2000 len 7, slave returns 0x10..0x17 -> rsp_valid[2] 8 beats, rsp_last on 8th, ARID=2.
REQ-035 Slave BRESP=2 on req1 write -> rsp_resp=2 to req1 only; next grant proceeds normally.
REQ-036 ARESETn low during WDATA beat 2 of len 7 -> outputs 0 same cycle, no rsp_valid, next grant to req0 if valid.
REQ-037 Req3 len 0 write with slave WREADY delayed 5 cycles -> single beat WLAST=1, req_wready[3] only during handshake.
